// File: rtl/mem_sp_arb2.sv
// Two-requester round-robin arbiter with burst allowance in front of a single-port sync memory.
// Define MEM_ARB_RSP_REG_EN to register the read response (latency 2 instead of 1).
module mem_sp_arb2 #(
    parameter int DEPTH      = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid_0,
    output logic                  o_req_ready_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [DATA_WIDTH-1:0] i_wdata_0,
    input  logic [DATA_BYTES-1:0] i_wen_0,
    output logic                  o_rsp_valid_0,
    output logic [DATA_WIDTH-1:0] o_rdata_0,

    input  logic                  i_req_valid_1,
    output logic                  o_req_ready_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [DATA_WIDTH-1:0] i_wdata_1,
    input  logic [DATA_BYTES-1:0] i_wen_1,
    output logic                  o_rsp_valid_1,
    output logic [DATA_WIDTH-1:0] o_rdata_1,

    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [DATA_BYTES-1:0] o_mem_wen,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    req_id_e    r_own;
    logic [7:0] r_cnt;
    req_id_e    w_other;
    logic       w_gnt_valid;
    req_id_e    w_gnt_id;
    logic       w_gnt_read;

    logic       r_tag_valid;
    req_id_e    r_tag_id;
    logic       w_tag_hit_0;
    logic       w_tag_hit_1;

    assign w_other = (r_own == REQ0) ? REQ1 : REQ0;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = REQ0;
        if (!rst) begin
            case ({i_req_valid_1, i_req_valid_0})
                2'b01: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = REQ0;
                end
                2'b10: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = REQ1;
                end
                2'b11: begin
                    // Owner keeps the port until its burst allowance is used up.
                    w_gnt_valid = 1'b1;
                    w_gnt_id    = (r_cnt < BURST_MAX) ? r_own : w_other;
                end
                default: begin
                    w_gnt_valid = 1'b0;
                    w_gnt_id    = REQ0;
                end
            endcase
        end
    end

    always_comb begin
        o_req_ready_0 = w_gnt_valid && (w_gnt_id == REQ0);
        o_req_ready_1 = w_gnt_valid && (w_gnt_id == REQ1);
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_mem_wen     = '0;
        w_gnt_read    = 1'b0;
        if (w_gnt_valid) begin
            if (w_gnt_id == REQ0) begin
                o_mem_addr  = i_addr_0;
                o_mem_wdata = i_wdata_0;
                o_mem_wen   = i_wen_0;
                w_gnt_read  = (i_wen_0 == '0);
            end else begin
                o_mem_addr  = i_addr_1;
                o_mem_wdata = i_wdata_1;
                o_mem_wen   = i_wen_1;
                w_gnt_read  = (i_wen_1 == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_own <= REQ0;
            r_cnt <= '0;
        end else if (w_gnt_valid) begin
            if (w_gnt_id == r_own) begin
                r_cnt <= (r_cnt == BURST_MAX) ? r_cnt : r_cnt + 8'd1;
            end else begin
                r_own <= w_gnt_id;
                r_cnt <= 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= 1'b0;
            r_tag_id    <= REQ0;
        end else begin
            r_tag_valid <= w_gnt_read;
            r_tag_id    <= w_gnt_id;
        end
    end

    assign w_tag_hit_0 = r_tag_valid && (r_tag_id == REQ0) && !rst;
    assign w_tag_hit_1 = r_tag_valid && (r_tag_id == REQ1) && !rst;

`ifdef MEM_ARB_RSP_REG_EN
    logic                  r_rsp_valid_0;
    logic                  r_rsp_valid_1;
    logic [DATA_WIDTH-1:0] r_rdata_0;
    logic [DATA_WIDTH-1:0] r_rdata_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
            r_rdata_0     <= '0;
            r_rdata_1     <= '0;
        end else begin
            r_rsp_valid_0 <= w_tag_hit_0;
            r_rsp_valid_1 <= w_tag_hit_1;
            r_rdata_0     <= w_tag_hit_0 ? i_mem_rdata : '0;
            r_rdata_1     <= w_tag_hit_1 ? i_mem_rdata : '0;
        end
    end

    // Reset masks registered responses so nothing leaks out while rst is high.
    assign o_rsp_valid_0 = r_rsp_valid_0 && !rst;
    assign o_rsp_valid_1 = r_rsp_valid_1 && !rst;
    assign o_rdata_0     = rst ? '0 : r_rdata_0;
    assign o_rdata_1     = rst ? '0 : r_rdata_1;
`else
    assign o_rsp_valid_0 = w_tag_hit_0;
    assign o_rsp_valid_1 = w_tag_hit_1;
    assign o_rdata_0     = w_tag_hit_0 ? i_mem_rdata : '0;
    assign o_rdata_1     = w_tag_hit_1 ? i_mem_rdata : '0;
`endif

endmodule

// File: tb/tb_mem_sp_arb2.sv
// Directed scoreboard bench for mem_sp_arb2 with a behavioural single-port sync memory.
module tb_mem_sp_arb2;

    localparam int DEPTH    = 2048;
    localparam int DW       = 32;
    localparam int DB       = DW / 8;
    localparam int AW       = $clog2(DEPTH);
    localparam int TB_BURST = 4;
`ifdef MEM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_0, req_ready_0, rsp_valid_0;
    logic          req_valid_1, req_ready_1, rsp_valid_1;
    logic [AW-1:0] addr_0, addr_1, mem_addr;
    logic [DW-1:0] wdata_0, wdata_1, rdata_0, rdata_1, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DB-1:0] wen_0, wen_1, mem_wen;

    logic [DW-1:0] mem     [DEPTH] = '{default: '0};
    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        int          due;
    } rsp_t;
    rsp_t q[$];
    rsp_t mon_e;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    mem_sp_arb2 #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BURST_LEN(TB_BURST)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid_0(req_valid_0), .o_req_ready_0(req_ready_0),
        .i_addr_0(addr_0), .i_wdata_0(wdata_0), .i_wen_0(wen_0),
        .o_rsp_valid_0(rsp_valid_0), .o_rdata_0(rdata_0),
        .i_req_valid_1(req_valid_1), .o_req_ready_1(req_ready_1),
        .i_addr_1(addr_1), .i_wdata_1(wdata_1), .i_wen_1(wen_1),
        .o_rsp_valid_1(rsp_valid_1), .o_rdata_1(rdata_1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < DB; b++)
            if (mem_wen[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response checker: every cycle, exactly the due entry (if any) must appear.
    always @(negedge clk) begin
        logic          ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.id == 0) begin ev0 = 1'b1; ed0 = mon_e.data; end
            else               begin ev1 = 1'b1; ed1 = mon_e.data; end
        end
        chk("rsp_valid_0", 64'(rsp_valid_0), 64'(ev0));
        chk("rdata_0",     64'(rdata_0),     64'(ed0));
        chk("rsp_valid_1", 64'(rsp_valid_1), 64'(ev1));
        chk("rdata_1",     64'(rdata_1),     64'(ed1));
    end

    // One cycle: drive at posedge+1, check grant and memory port at negedge, update model.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [DB-1:0] w0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [DB-1:0] w1, input int g);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DB-1:0] ew;
        req_valid_0 = v0; req_valid_1 = v1;
        addr_0  = v0 ? a0 : AW'(12'h5a5);
        wdata_0 = v0 ? d0 : 32'hcafef00d;
        wen_0   = v0 ? w0 : '1;
        addr_1  = v1 ? a1 : AW'(12'h3c3);
        wdata_1 = v1 ? d1 : 32'h0badf00d;
        wen_1   = v1 ? w1 : '1;
        ea = (g == 0) ? a0 : (g == 1) ? a1 : '0;
        ed = (g == 0) ? d0 : (g == 1) ? d1 : '0;
        ew = (g == 0) ? w0 : (g == 1) ? w1 : '0;
        @(negedge clk);
        chk("ready_0",   64'(req_ready_0), 64'(g == 0));
        chk("ready_1",   64'(req_ready_1), 64'(g == 1));
        chk("mem_addr",  64'(mem_addr),    64'(ea));
        chk("mem_wdata", 64'(mem_wdata),   64'(ed));
        chk("mem_wen",   64'(mem_wen),     64'(ew));
        if (g >= 0) begin
            if (ew == '0) begin
                q.push_back('{id: g, data: ref_mem[ea], due: cyc + LAT});
            end else begin
                for (int b = 0; b < DB; b++)
                    if (ew[b]) ref_mem[ea][b*8 +: 8] = ed[b*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, -1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < n; i++)
            step(1, AW'(3), 32'h11111111, 4'hf, 1, AW'(4), 32'h22222222, 4'hf, -1);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1;
        req_valid_0 = 0; req_valid_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0; wen_0 = '0; wen_1 = '0;
        @(posedge clk);
        #1;

        // Reset held with both requesting: no grant, no write, no response.
        do_reset(5);
        step(1, AW'(3), 32'h1, '0, 1, AW'(5), 32'h2, '0, 0);
        idle(2);

        // Single requester partial write then read-back.
        step(1, AW'(7), 32'hffffff05, 4'h5, 0, '0, '0, '0, 0);
        step(1, AW'(7), 32'h0, 4'h0, 0, '0, '0, '0, 0);
        idle(3);
        step(0, '0, '0, '0, 1, AW'(7), 32'h77, 4'h2, 1);
        step(0, '0, '0, '0, 1, AW'(7), 32'h0, 4'h0, 1);
        idle(3);

        // Same-address collision: write from 0 wins the tie, read from 1 follows.
        do_reset(1);
        step(1, AW'(100), 32'hdeadbeef, 4'hf, 1, AW'(100), 32'h0, 4'h0, 0);
        step(0, '0, '0, '0, 1, AW'(100), 32'h0, 4'h0, 1);
        idle(3);

        // Mid-flight reset: read from 1 then reset; tie afterwards goes to 0.
        step(0, '0, '0, '0, 1, AW'(100), 32'h0, 4'h0, 1);
        do_reset(3);
        step(1, AW'(7), 32'h0, 4'h0, 1, AW'(100), 32'h0, 4'h0, 0);
        idle(3);

        // Prefill by requester 1, then a continuous two-requester read stream.
        for (int i = 0; i < 128; i++)
            step(0, '0, '0, '0, 1, AW'(i), DW'(DEPTH - i), 4'hf, 1);
        do_reset(1);
        a0 = 0;
        a1 = 64;
        for (int k = 0; k < 64; k++) begin
            int g;
            g = (k / TB_BURST) % 2;
            step(1, AW'(a0), DW'($urandom), '0, 1, AW'(a1), DW'($urandom), '0, g);
            if (g == 0) a0++; else a1++;
        end
        idle(4);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
